// File: rtl/seq_detect_param.sv
// seq_detect_param
//   Parametrised serial pattern detector on a 1-bit data path. It keeps a short
//   history of the most recent enabled bits. It raises a Mealy pulse when that
//   history plus the current bit equals the loaded pattern. The pattern can be
//   reloaded at run time, and matching can be overlapping or non-overlapping.
//   A saturating match counter with a sticky saturation flag follows the pulse.
//
// Parameters
//   PAT_W    pattern length in bits (2..32)
//   PATTERN  pattern loaded at reset; PATTERN[PAT_W-1] is the first bit received
//   CNT_W    match counter width (>= 1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         din is valid this cycle
//   din        serial data bit
//   overlap    1 = overlapping matches, 0 = matched bits are consumed
//   pat_load   load pat_in into the pattern register (discards din and history)
//   pat_in     new pattern, same bit order as PATTERN
//   clear      synchronous clear of match_cnt and cnt_sat
//   dout       combinational match pulse
//   match_q    dout delayed by one clock
//   match_cnt  saturating match count
//   cnt_sat    sticky flag: match_cnt has reached all-ones
module seq_detect_param #(
  parameter int unsigned       PAT_W   = 3,
  parameter logic [PAT_W-1:0]  PATTERN = 3'b101,
  parameter int unsigned       CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             clear,
  output logic             dout,
  output logic             match_q,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  if (PAT_W < 2 || PAT_W > 32) begin : g_bad_pat_w
    $error("seq_detect_param: PAT_W must be in 2..32");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("seq_detect_param: CNT_W must be at least 1");
  end

  localparam int unsigned        FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat_reg;
  logic [PAT_W-2:0]  hist;
  logic [FILL_W-1:0] fill;

  logic [PAT_W-1:0]  window;
  logic              full;
  logic [PAT_W-2:0]  hist_nxt;
  logic [FILL_W-1:0] fill_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              sat_nxt;

  // Match decision and history update
  always_comb begin
    window   = {hist, din};
    full     = (fill == FILL_MAX);
    dout     = en & ~pat_load & full & (window == pat_reg);
    hist_nxt = hist;
    fill_nxt = fill;
    if (pat_load) begin
      hist_nxt = '0;
      fill_nxt = '0;
    end else if (en) begin
      if (dout && !overlap) begin
        hist_nxt = '0;
        fill_nxt = '0;
      end else begin
        // Dropping the MSB of {hist, din} is the shift; also covers PAT_W = 2.
        hist_nxt = window[PAT_W-2:0];
        fill_nxt = full ? fill : fill + 1'b1;
      end
    end
  end

  // Saturating counter; clear wins over a same-cycle match
  always_comb begin
    cnt_nxt = match_cnt;
    sat_nxt = cnt_sat;
    if (clear) begin
      cnt_nxt = '0;
      sat_nxt = 1'b0;
    end else begin
      if (dout && (match_cnt != '1)) begin
        cnt_nxt = match_cnt + 1'b1;
      end
      if (cnt_nxt == '1) begin
        sat_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_reg   <= PATTERN;
      hist      <= '0;
      fill      <= '0;
      match_q   <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      if (pat_load) begin
        pat_reg <= pat_in;
      end
      hist      <= hist_nxt;
      fill      <= fill_nxt;
      match_q   <= dout;
      match_cnt <= cnt_nxt;
      cnt_sat   <= sat_nxt;
    end
  end

endmodule
